// File: rtl/mem_stage_p.sv
// Memory stage for the omicron pipeline: synchronous data RAM, extended branch decode and aligned output registers.
// Optional upper-address range checking is enabled by defining MEM_STAGE_ADDR_CHECK_EN.
module mem_stage_p #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7,
   parameter int RA_W   = 3
) (
   input  logic              clk_n,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              stall,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_register2_data,
   input  logic [RA_W-1:0]   ex_reg_waddr,
   input  logic              cu_dm_wea,
   input  logic              cu_dm_rea,
   input  logic [2:0]        cu_branch,
   input  logic              ex_alu_z,
   input  logic              ex_alu_n,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_alu_result,
   output logic [DATA_W-1:0] m_dm_dout,
   output logic [RA_W-1:0]   m_reg_waddr,
   output logic              m_load,
   output logic              m_branch_en,
   output logic              m_addr_err
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] BR_DBR = 3'b000;
   localparam logic [2:0] BR_BEQ = 3'b001;
   localparam logic [2:0] BR_BNE = 3'b010;
   localparam logic [2:0] BR_JMP = 3'b011;
   localparam logic [2:0] BR_BLT = 3'b100;
   localparam logic [2:0] BR_BGE = 3'b101;
   localparam logic [2:0] BR_BLE = 3'b110;
   localparam logic [2:0] BR_BGT = 3'b111;

   function automatic logic branch_decode(input logic [2:0] code, input logic z, input logic n);
      logic taken;
      case (code)
         BR_DBR:  taken = 1'b0;
         BR_BEQ:  taken = z;
         BR_BNE:  taken = ~z;
         BR_JMP:  taken = 1'b1;
         BR_BLT:  taken = n;
         BR_BGE:  taken = ~n;
         BR_BLE:  taken = z | n;
         BR_BGT:  taken = ~z & ~n;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   logic              accept_s;
   logic [ADDR_W-1:0] addr_s;
   logic              err_s;
   logic              store_s;
   logic              load_s;
   logic              branch_s;

   logic              valid_r;
   logic [DATA_W-1:0] alu_result_r;
   logic [DATA_W-1:0] dm_dout_r;
   logic [RA_W-1:0]   reg_waddr_r;
   logic              load_r;
   logic              branch_en_r;

   assign accept_s = ex_valid & ~stall;
   assign addr_s   = ex_alu_result[ADDR_W-1:0];

   // Range check on the address bits above the RAM index; constant 0 when there are none or the check is off.
   generate
`ifdef MEM_STAGE_ADDR_CHECK_EN
      if (DATA_W > ADDR_W) begin : g_addr_chk
         assign err_s = |ex_alu_result[DATA_W-1:ADDR_W];
      end else begin : g_addr_nochk
         assign err_s = 1'b0;
      end
`else
      if (DATA_W > ADDR_W) begin : g_addr_wrap
         logic unused_upper_s;
         assign unused_upper_s = &{1'b0, ex_alu_result[DATA_W-1:ADDR_W]};
      end
      assign err_s = 1'b0;
`endif
   endgenerate

   // A simultaneous store and load acts as a store only.
   assign store_s  = accept_s & cu_dm_wea & ~err_s;
   assign load_s   = accept_s & cu_dm_rea & ~cu_dm_wea;
   assign branch_s = branch_decode(cu_branch, ex_alu_z, ex_alu_n);

   // Data RAM write port; contents are never reset and a reset cycle blocks the write.
   always_ff @(posedge clk_n) begin
      if (!rst && store_s) begin
         mem_r[addr_s] <= ex_register2_data;
      end
   end

   // Output registers; dm_dout_r doubles as the hold register so stalls are immune to later RAM writes.
   always_ff @(posedge clk_n) begin
      if (rst) begin
         valid_r      <= 1'b0;
         alu_result_r <= {DATA_W{1'b0}};
         dm_dout_r    <= {DATA_W{1'b0}};
         reg_waddr_r  <= {RA_W{1'b0}};
         load_r       <= 1'b0;
         branch_en_r  <= 1'b0;
      end else if (stall) begin
         valid_r      <= valid_r;
         alu_result_r <= alu_result_r;
         dm_dout_r    <= dm_dout_r;
         reg_waddr_r  <= reg_waddr_r;
         load_r       <= load_r;
         branch_en_r  <= branch_en_r;
      end else if (ex_valid) begin
         valid_r      <= 1'b1;
         alu_result_r <= ex_alu_result;
         reg_waddr_r  <= ex_reg_waddr;
         load_r       <= load_s;
         branch_en_r  <= branch_s;
         if (load_s) begin
            dm_dout_r <= err_s ? {DATA_W{1'b0}} : mem_r[addr_s];
         end else begin
            dm_dout_r <= dm_dout_r;
         end
      end else begin
         valid_r      <= 1'b0;
         alu_result_r <= alu_result_r;
         dm_dout_r    <= dm_dout_r;
         reg_waddr_r  <= reg_waddr_r;
         load_r       <= 1'b0;
         branch_en_r  <= 1'b0;
      end
   end

`ifdef MEM_STAGE_ADDR_CHECK_EN
   logic addr_err_r;

   // Error flag travels with its instruction, cleared by bubbles and reset.
   always_ff @(posedge clk_n) begin
      if (rst) begin
         addr_err_r <= 1'b0;
      end else if (stall) begin
         addr_err_r <= addr_err_r;
      end else if (ex_valid) begin
         addr_err_r <= err_s;
      end else begin
         addr_err_r <= 1'b0;
      end
   end

   assign m_addr_err = addr_err_r;
`else
   assign m_addr_err = 1'b0;
`endif

   assign m_valid      = valid_r;
   assign m_alu_result = alu_result_r;
   assign m_dm_dout    = dm_dout_r;
   assign m_reg_waddr  = reg_waddr_r;
   assign m_load       = load_r;
   assign m_branch_en  = branch_en_r;

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed self-checking bench for mem_stage_p; expected values are hand-derived constants.
module tb_mem_stage_p;

   logic        clk_n = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] ex_alu_result = 16'h0000;
   logic [15:0] ex_register2_data = 16'h0000;
   logic [2:0]  ex_reg_waddr = 3'd0;
   logic        cu_dm_wea = 1'b0;
   logic        cu_dm_rea = 1'b0;
   logic [2:0]  cu_branch = 3'd0;
   logic        ex_alu_z = 1'b0;
   logic        ex_alu_n = 1'b0;
   logic        m_valid;
   logic [15:0] m_alu_result;
   logic [15:0] m_dm_dout;
   logic [2:0]  m_reg_waddr;
   logic        m_load;
   logic        m_branch_en;
   logic        m_addr_err;

   int check_cnt = 0;
   int error_cnt = 0;

   mem_stage_p #(.DATA_W(16), .ADDR_W(7), .RA_W(3)) dut (
      .clk_n(clk_n), .rst(rst), .ex_valid(ex_valid), .stall(stall),
      .ex_alu_result(ex_alu_result), .ex_register2_data(ex_register2_data),
      .ex_reg_waddr(ex_reg_waddr), .cu_dm_wea(cu_dm_wea), .cu_dm_rea(cu_dm_rea),
      .cu_branch(cu_branch), .ex_alu_z(ex_alu_z), .ex_alu_n(ex_alu_n),
      .m_valid(m_valid), .m_alu_result(m_alu_result), .m_dm_dout(m_dm_dout),
      .m_reg_waddr(m_reg_waddr), .m_load(m_load), .m_branch_en(m_branch_en),
      .m_addr_err(m_addr_err)
   );

   always #5 clk_n = ~clk_n;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [2:0] wa, input logic we, input logic re);
      ex_valid = v; stall = st; ex_alu_result = alu; ex_register2_data = wd;
      ex_reg_waddr = wa; cu_dm_wea = we; cu_dm_rea = re;
   endtask

   task automatic tick();
      @(posedge clk_n);
      #1;
   endtask

   initial begin
      logic exp_br;
      logic [15:0] exp_dout;

      // Reset state and a known RAM word at address 12.
      rst = 1'b1; drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b0; drive(1'b1, 1'b0, 16'h000C, 16'h1111, 3'd6, 1'b1, 1'b0);
      tick();
      check_eq("pre_rst_valid", m_valid, 1);
      rst = 1'b1; drive(1'b1, 1'b1, 16'h000C, 16'hDEAD, 3'd7, 1'b1, 1'b0);
      cu_branch = 3'b011;
      tick();
      stall = 1'b0;
      tick();
      check_eq("rst_valid", m_valid, 0);
      check_eq("rst_alu", m_alu_result, 0);
      check_eq("rst_dout", m_dm_dout, 0);
      check_eq("rst_waddr", m_reg_waddr, 0);
      check_eq("rst_load", m_load, 0);
      check_eq("rst_br", m_branch_en, 0);
      check_eq("rst_err", m_addr_err, 0);
      rst = 1'b0; cu_branch = 3'b000;
      drive(1'b1, 1'b0, 16'h000C, 16'h0000, 3'd1, 1'b0, 1'b1);
      tick();
      check_eq("rst_no_write", m_dm_dout, 16'h1111);

      // Store then load back-to-back.
      drive(1'b1, 1'b0, 16'h0005, 16'hBEEF, 3'd2, 1'b1, 1'b0);
      tick();
      check_eq("st_valid", m_valid, 1);
      check_eq("st_load", m_load, 0);
      drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd3, 1'b0, 1'b1);
      tick();
      check_eq("ld_dout", m_dm_dout, 16'hBEEF);
      check_eq("ld_load", m_load, 1);
      check_eq("ld_valid", m_valid, 1);
      check_eq("ld_waddr", m_reg_waddr, 3);
      check_eq("ld_alu", m_alu_result, 16'h0005);

      // Branch sweep over all codes and flag combinations.
      for (int c = 0; c < 8; c++) begin
         for (int f = 0; f < 4; f++) begin
            drive(1'b1, 1'b0, 16'h0040, 16'h0000, 3'd4, 1'b0, 1'b0);
            cu_branch = 3'(c); ex_alu_z = f[1]; ex_alu_n = f[0];
            case (c)
               0: exp_br = 1'b0;
               1: exp_br = (f == 2 || f == 3);
               2: exp_br = (f == 0 || f == 1);
               3: exp_br = 1'b1;
               4: exp_br = (f == 1 || f == 3);
               5: exp_br = (f == 0 || f == 2);
               6: exp_br = (f != 0);
               default: exp_br = (f == 0);
            endcase
            tick();
            check_eq($sformatf("br_c%0d_zn%0d", c, f), m_branch_en, exp_br);
         end
      end
      drive(1'b0, 1'b0, 16'h0077, 16'h0000, 3'd5, 1'b0, 1'b0);
      cu_branch = 3'b011;
      tick();
      check_eq("jmp_bubble_br", m_branch_en, 0);
      check_eq("bubble_valid", m_valid, 0);
      check_eq("bubble_alu_hold", m_alu_result, 16'h0040);
      check_eq("bubble_dout_hold", m_dm_dout, 16'hBEEF);
      cu_branch = 3'b000; ex_alu_z = 1'b0; ex_alu_n = 1'b0;

      // Stall during a load while the RAM word changes underneath.
      drive(1'b1, 1'b0, 16'h0003, 16'h1234, 3'd1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 16'h0003, 16'h0000, 3'd2, 1'b0, 1'b1);
      tick();
      check_eq("stl_ld_dout", m_dm_dout, 16'h1234);
      drive(1'b1, 1'b1, 16'h0005, 16'h0000, 3'd6, 1'b0, 1'b1);
      for (int s = 0; s < 3; s++) begin
         tick();
         if (s == 0) dut.mem_r[3] = 16'h0000;
         check_eq($sformatf("stl_dout_%0d", s), m_dm_dout, 16'h1234);
         check_eq($sformatf("stl_valid_%0d", s), m_valid, 1);
         check_eq($sformatf("stl_waddr_%0d", s), m_reg_waddr, 2);
      end
      drive(1'b1, 1'b0, 16'h0003, 16'h0000, 3'd2, 1'b0, 1'b1);
      tick();
      check_eq("post_stl_reload", m_dm_dout, 16'h0000);

      // Upper address bits: range error or wrap.
      drive(1'b1, 1'b0, 16'h0085, 16'h7777, 3'd3, 1'b1, 1'b0);
      tick();
`ifdef MEM_STAGE_ADDR_CHECK_EN
      check_eq("oor_err", m_addr_err, 1);
      exp_dout = 16'hBEEF;
`else
      check_eq("oor_err", m_addr_err, 0);
      exp_dout = 16'h7777;
`endif
      drive(1'b1, 1'b0, 16'h0005, 16'h0000, 3'd3, 1'b0, 1'b1);
      tick();
      check_eq("oor_addr5", m_dm_dout, exp_dout);
      check_eq("oor_err_clr", m_addr_err, 0);
`ifdef MEM_STAGE_ADDR_CHECK_EN
      drive(1'b1, 1'b0, 16'h0085, 16'h0000, 3'd3, 1'b0, 1'b1);
      tick();
      check_eq("oor_ld_zero", m_dm_dout, 16'h0000);
      check_eq("oor_ld_err", m_addr_err, 1);
      exp_dout = 16'h0000;
`else
      drive(1'b1, 1'b0, 16'h0080, 16'h5555, 3'd3, 1'b1, 1'b0);
      tick();
      drive(1'b1, 1'b0, 16'h0000, 16'h0000, 3'd3, 1'b0, 1'b1);
      tick();
      check_eq("wrap_addr0", m_dm_dout, 16'h5555);
      exp_dout = 16'h5555;
`endif

      // Simultaneous store and load acts as a store.
      drive(1'b1, 1'b0, 16'h0009, 16'h00AA, 3'd4, 1'b1, 1'b1);
      tick();
      check_eq("both_load", m_load, 0);
      check_eq("both_dout_hold", m_dm_dout, exp_dout);
      check_eq("both_valid", m_valid, 1);
      drive(1'b1, 1'b0, 16'h0009, 16'h0000, 3'd4, 1'b0, 1'b1);
      tick();
      check_eq("both_readback", m_dm_dout, 16'h00AA);
      check_eq("both_rb_load", m_load, 1);

      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
      tick();
      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parametrised memory stage for the omicron pipeline. It sits between the execute stage and write-back, and does three things: it owns an inferred synchronous data RAM, it decodes an extended branch-condition set, and it registers every result so that data, destination address and branch decision leave the stage aligned. It also adds a valid/stall handshake, load tagging and optional address range checking.

## Interface
Parameters:
- DATA_W, 16: data and ALU result width.
- ADDR_W, 7: data RAM address width; the RAM depth is 2^ADDR_W words of DATA_W bits.
- RA_W, 3: register-file write address width.

Ports:
- clk_n  in  1  stage clock, rising-edge active.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- stall  in  1  hold the stage; no state changes except under reset.
- ex_alu_result  in  DATA_W  ALU result; also the memory address.
- ex_register2_data  in  DATA_W  store data.
- ex_reg_waddr  in  RA_W  destination register.
- cu_dm_wea  in  1  store.
- cu_dm_rea  in  1  load.
- cu_branch  in  3  branch condition code.
- ex_alu_z  in  1  ALU zero flag.
- ex_alu_n  in  1  ALU negative flag.
- m_valid  out  1  stage outputs valid.
- m_alu_result  out  DATA_W  registered ALU result.
- m_dm_dout  out  DATA_W  load data.
- m_reg_waddr  out  RA_W  registered destination register.
- m_load  out  1  the instruction was a load; selects m_dm_dout at write-back.
- m_branch_en  out  1  take branch or jump.
- m_addr_err  out  1  address out of range.

## Operation
- Accept condition: accept = ex_valid & ~stall.
- Address: addr = ex_alu_result[ADDR_W-1:0]. If DATA_W > ADDR_W, the bits above ADDR_W are range-checked (see Configuration).
- Store: the RAM word at addr is written with ex_register2_data on the edge where accept & cu_dm_wea & ~err hold. Here err is the range-check result.
- Load: the RAM word at addr is read synchronously on an accepting edge. The word is presented on m_dm_dout in the same cycle as m_valid.
- Store and load asserted together: treated as a store only. m_load = 0 and m_dm_dout holds its previous value.
- Branch decode on cu_branch, producing m_branch_en:
  - 000 DBR: 0.
  - 001 BEQ: z.
  - 010 BNE: ~z.
  - 011 JMP: 1.
  - 100 BLT: n.
  - 101 BGE: ~n.
  - 110 BLE: z | n.
  - 111 BGT: ~z & ~n.
- m_branch_en is set only for accepted instructions.
- Bubble (ex_valid = 0, stall = 0):
  - m_valid, m_load, m_branch_en and m_addr_err clear to 0.
  - m_alu_result, m_reg_waddr and m_dm_dout hold their values.
  - No RAM access.
- Stall: every output register and the RAM hold. A held m_dm_dout must not change even if the RAM array is modified elsewhere, so an output hold register is required.
- Reset:
  - rst = 1 on an edge clears every output to 0: m_valid, m_alu_result, m_dm_dout, m_reg_waddr, m_load, m_branch_en and m_addr_err.
  - Reset overrides stall and any in-flight store; no RAM write occurs in a reset cycle.
  - RAM contents are not reset.

## Timing
- Latency is 1 cycle for every output, from an accepting edge to registered outputs.
- Throughput is one instruction per cycle when stall = 0.
- A store at edge t to address A followed by a load at edge t+1 from A returns the stored data. This needs no bypass.
- stall is sampled at each edge. When stall rises, the outputs of the last accepted instruction remain visible until the first edge with stall = 0.
- m_branch_en is valid only when m_valid = 1. The fetch stage qualifies its redirect with m_valid.
- Address wrap: with range checking disabled, address 2^ADDR_W aliases to 0.

## Configuration
- Macro MEM_STAGE_ADDR_CHECK_EN, when defined:
  - err = |ex_alu_result[DATA_W-1:ADDR_W].
  - An erroring store is suppressed.
  - An erroring load returns 0 on m_dm_dout.
  - m_addr_err = 1 alongside m_valid for that instruction.
- When undefined:
  - Upper address bits are ignored, so addresses wrap.
  - m_addr_err is tied to 0.
  - No comparison logic is built.
- With DATA_W == ADDR_W, err is constant 0 in both builds.

## Test plan
- Reset: drive rst = 1 for 2 cycles with ex_valid = 1 and cu_dm_wea = 1 -> all outputs are 0 and no RAM write occurs (a later load from that address returns the old contents).
- Store/load back-to-back: store 16'hBEEF at address 5, then load address 5 on the next cycle -> m_dm_dout = 16'hBEEF, m_load = 1, m_valid = 1, both one cycle after the load is accepted.
- Branch sweep: apply all 8 cu_branch codes against all four (z, n) combinations -> m_branch_en matches the decode list; a code-011 jump with ex_valid = 0 gives m_branch_en = 0.
- Stall mid-load: load address 3 (containing 16'h1234), assert stall for 3 cycles, and store 16'h0000 to address 3 from the bench backdoor -> m_dm_dout stays 16'h1234 throughout the stall.
- Out of range (macro defined, DATA_W = 16, ADDR_W = 7): store at 16'h0085 -> m_addr_err = 1 and address 5 is unchanged. With the macro undefined, the same store writes address 5 and m_addr_err = 0.
- Simultaneous store and load at address 9 with data 16'h00AA -> m_load = 0 and m_dm_dout held; a subsequent load from address 9 returns 16'h00AA.
